// File: rtl/asrv32_fetch.sv
// ASRV32 instruction-fetch stage: owns the PC, issues single-outstanding
// instruction reads and hands {inst, pc} to the decoder through a one-entry skid buffer.
module asrv32_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [31:0] o_iaddr,
   output logic        o_stb_inst,
   input  logic        i_ack_inst,
   input  logic [31:0] i_inst,
   input  logic        i_change_pc_alu,
   input  logic [31:0] i_next_pc_alu,
   input  logic        i_change_pc_wb,
   input  logic [31:0] i_next_pc_wb,
   output logic [31:0] o_inst_ifid,
   output logic [31:0] o_pc_ifid,
   output logic        o_ce,
   input  logic        i_stall,
   input  logic        i_flush
);

   logic [31:0] pc_q, pc_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] inst_ifid_q, inst_ifid_d;
   logic [31:0] pc_ifid_q, pc_ifid_d;
   logic        ce_q, ce_d;
   logic        fire;
   logic [31:0] target;

   assign o_stb_inst  = !buf_valid_q;
   assign o_iaddr     = pc_q;
   assign o_inst_ifid = inst_ifid_q;
   assign o_pc_ifid   = pc_ifid_q;
   assign o_ce        = ce_q;
   assign fire        = o_stb_inst && i_ack_inst;
   assign target      = i_change_pc_wb ? i_next_pc_wb : i_next_pc_alu;

   always_comb begin
      pc_d        = pc_q;
      buf_valid_d = buf_valid_q;
      buf_inst_d  = buf_inst_q;
      buf_pc_d    = buf_pc_q;
      inst_ifid_d = inst_ifid_q;
      pc_ifid_d   = pc_ifid_q;
      ce_d        = ce_q;
      if (i_change_pc_wb || i_change_pc_alu) begin
         pc_d        = {target[31:2], 2'b00};
         buf_valid_d = 1'b0;
         ce_d        = 1'b0;
      end else if (i_flush) begin
         // pc is left alone so the squashed address is simply fetched again
         buf_valid_d = 1'b0;
         ce_d        = 1'b0;
      end else if (i_stall) begin
         if (fire) begin
            buf_inst_d  = i_inst;
            buf_pc_d    = pc_q;
            buf_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
         end
      end else if (buf_valid_q) begin
         inst_ifid_d = buf_inst_q;
         pc_ifid_d   = buf_pc_q;
         ce_d        = 1'b1;
         buf_valid_d = 1'b0;
      end else if (fire) begin
         inst_ifid_d = i_inst;
         pc_ifid_d   = pc_q;
         ce_d        = 1'b1;
         pc_d        = pc_q + 32'd4;
      end else begin
         ce_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_q        <= PC_RESET;
         buf_valid_q <= 1'b0;
         buf_inst_q  <= 32'd0;
         buf_pc_q    <= 32'd0;
         inst_ifid_q <= 32'd0;
         pc_ifid_q   <= 32'd0;
         ce_q        <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         buf_valid_q <= buf_valid_d;
         buf_inst_q  <= buf_inst_d;
         buf_pc_q    <= buf_pc_d;
         inst_ifid_q <= inst_ifid_d;
         pc_ifid_q   <= pc_ifid_d;
         ce_q        <= ce_d;
      end
   end

endmodule

// File: doc/asrv32_fetch.md
# asrv32_fetch

Instruction-fetch (IF) stage of the ASRV32 pipeline, directly upstream of the decoder. It owns the program counter and issues single-outstanding reads to instruction memory. It presents `{instruction, PC}` with a valid strobe to the decoder, and absorbs downstream stalls with a one-entry skid buffer. It applies PC redirects from execute (taken branch/jump) and writeback (trap/mret).

## Interface
- `PC_RESET`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `o_iaddr`  out  32  instruction address, equal to `pc`.
- `o_stb_inst`  out  1  fetch request, combinational, `= !buf_valid`.
- `i_ack_inst`  in  1  memory ack; *fire* = `o_stb_inst && i_ack_inst`, same cycle.
- `i_inst`  in  32  instruction word, valid in the fire cycle only.
- `i_change_pc_alu`  in  1  execute redirect request.
- `i_next_pc_alu`  in  32  execute redirect target.
- `i_change_pc_wb`  in  1  writeback redirect request; has priority over ALU.
- `i_next_pc_wb`  in  32  writeback redirect target.
- `o_inst_ifid`  out  32  instruction to decoder.
- `o_pc_ifid`  out  32  PC of `o_inst_ifid`.
- `o_ce`  out  1  `o_inst_ifid` / `o_pc_ifid` valid (clock enable for decoder).
- `i_stall`  in  1  downstream stall; hold IF/ID outputs.
- `i_flush`  in  1  discard IF/ID contents and buffered fetch.

## Operation
- **State:** `pc[31:0]`, `buf_valid`, `buf_inst[31:0]`, `buf_pc[31:0]`, and the output registers.
- **Reset:** `pc = PC_RESET`; `o_ce = 0`; `o_inst_ifid = 0`; `o_pc_ifid = 0`; `buf_valid = 0`; `buf_inst = 0`; `buf_pc = 0`. Combinational outputs after reset: `o_stb_inst = 1`, `o_iaddr = PC_RESET`.
- **Per-cycle priority (first match wins):**
  1. **Redirect** (`i_change_pc_wb || i_change_pc_alu`):
     - `pc <= {target[31:2], 2'b00}`, where target is the WB value if `i_change_pc_wb`, else the ALU value.
     - `buf_valid <= 0`; `o_ce <= 0`.
     - Any fire this cycle is discarded. Redirect wins over `i_stall` and `i_flush`.
  2. **Flush** (`i_flush`): `o_ce <= 0`; `buf_valid <= 0`; any fire is discarded; `pc` unchanged, so the same address is refetched.
  3. **Stall** (`i_stall`):
     - `o_ce`, `o_inst_ifid`, `o_pc_ifid` hold.
     - If fire (implies buffer empty): `buf_inst <= i_inst`, `buf_pc <= pc`, `buf_valid <= 1`, `pc <= pc + 4`.
     - Once the buffer is full, `o_stb_inst` stays 0 until it drains.
  4. **Run:**
     - If `buf_valid`: `o_inst_ifid <= buf_inst`, `o_pc_ifid <= buf_pc`, `o_ce <= 1`, `buf_valid <= 0`. No fire is possible this cycle.
     - Else if fire: `o_inst_ifid <= i_inst`, `o_pc_ifid <= pc`, `o_ce <= 1`, `pc <= pc + 4`.
     - Else: `o_ce <= 0` (bubble); data outputs hold.
- **Arithmetic:** `pc + 4` is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- **Ordering:** instructions are delivered in PC order; none is duplicated or dropped except by redirect or flush.

## Timing
- **Fetch-to-decoder latency:** 1 cycle; a fire at edge N gives `o_ce = 1` after edge N.
- **Back-to-back:** with ack held high and no stall, `o_ce = 1` every cycle and the PC advances by 4 per cycle.
- **Wait states:** `o_stb_inst` and `o_iaddr` stay stable until fire; `o_ce = 0` for each wait cycle.
- **Redirect:**
  - Redirect asserted in cycle N: `o_iaddr = target` in N+1.
  - First redirected instruction appears with `o_ce = 1` no earlier than N+2.
  - Exactly the fetch in cycle N is squashed.
- **Stall release:** a buffered instruction is presented the cycle after `i_stall` drops; fetching resumes the cycle after that.
- **Reset assertion:** clears all state immediately, independent of the clock, including mid-stall with the buffer full.

## Test plan
- **Reset + straight-line fetch:** release `i_rst`, ack held at 1, `i_inst = 32'h0000_0013 + pc`.
  - `o_iaddr` runs 0x0, 0x4, 0x8, …
  - `o_ce = 1` from the 2nd edge, with `o_pc_ifid` lagging `o_iaddr` by one cycle.
- **Wait states:** ack high only every 3rd cycle.
  - `o_iaddr` is held for 3 cycles per fetch.
  - `o_ce` pattern is 0,0,1 repeating; PCs are sequential.
- **Stall with skid:** assert `i_stall` for 4 cycles with ack high.
  - IF/ID outputs hold.
  - Exactly one fetch is buffered, then `o_stb_inst = 0`.
  - After release, the buffered PC appears next, then `pc + 4`; nothing is lost or repeated.
- **Redirect priority:** in one cycle, `i_change_pc_wb = 1` (0x100), `i_change_pc_alu = 1` (0x200), `i_stall = 1`, buffer full.
  - Next cycle: `o_iaddr = 0x100`, `buf_valid = 0`, `o_ce = 0`.
  - The in-flight instruction never reaches the decoder.
- **Flush alone:** at PC 0x40, assert `i_flush` with ack.
  - Next cycle: `o_ce = 0` and `o_iaddr` is still 0x40.
  - Then `o_pc_ifid = 0x40` is delivered.
- **Wrap + async reset:**
  - Redirect to 0xFFFF_FFFC: the next `o_iaddr` is 0x0.
  - Assert `i_rst` mid-cycle while stalled: outputs and `o_ce` clear immediately, and `o_iaddr = PC_RESET`.
